// File: rtl/iter_mul18_ctrl.sv
// iter_mul18_ctrl: iterative shift-add 18-bit unsigned multiplier driving an external adder
module iter_mul18_ctrl #(
  parameter int WIDTH = 18,
  parameter int STEPS = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic [WIDTH-1:0] add_src1,
  output logic [WIDTH-1:0] add_src2,
  input  logic [WIDTH-1:0] add_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = $clog2(STEPS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0] count;
  logic ovf_int, run, step_ovf;
  assign run = state == RUN;
  assign add_src1 = run ? acc : '0;
  assign add_src2 = (run && mplier[0]) ? mcand : '0;
  // overflow: adder wrapped, or a set multiplicand bit leaves while multiplier bits remain
  assign step_ovf = (add_sum < add_src1) | ((|mplier[WIDTH-1:1]) & mcand[WIDTH-1]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      ovf_int     <= 1'b0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      result      <= '0;
      ovf         <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          state       <= RUN;
          mcand       <= op_a;
          mplier      <= op_b;
          acc         <= '0;
          count       <= '0;
          ovf_int     <= 1'b0;
          start_ready <= 1'b0;
          busy        <= 1'b1;
        end
        RUN: begin
          acc     <= add_sum;
          ovf_int <= ovf_int | step_ovf;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          count   <= count + 1'b1;
          if (count == CW'(STEPS - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            result    <= add_sum;
            ovf       <= ovf_int | step_ovf;
          end
        end
        DONE: if (res_ready) begin
          state       <= IDLE;
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_mul18_ctrl.sv
// tb_iter_mul18_ctrl: directed vector table plus hand sequences for hold, reset and flush
module tb_iter_mul18_ctrl;
  logic clk, rst_n, start_valid, start_ready, flush, res_valid, res_ready, ovf, busy;
  logic [17:0] op_a, op_b, add_src1, add_src2, add_sum, result;
  int checks = 0, failures = 0, run_obs, src2_nz, lat, seen;
  typedef struct {logic [17:0] a, b, r; logic o;} vec_t;
  vec_t v[8];

  iter_mul18_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .flush(flush), .add_src1(add_src1), .add_src2(add_src2),
    .add_sum(add_sum), .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .ovf(ovf), .busy(busy)
  );

  // the external 18-bit adder
  assign add_sum = add_src1 + add_src2;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  task automatic mul(input logic [17:0] a, input logic [17:0] b, output int l);
    @(negedge clk);
    start_valid = 1; op_a = a; op_b = b;
    @(negedge clk);
    start_valid = 0;
    l = 0; run_obs = 0; src2_nz = 0;
    while (!res_valid && l < 40) begin
      run_obs++;
      if (add_src2 != 0) src2_nz = 1;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    v[0] = '{18'd123, 18'd456, 18'd56088, 1'b0};
    v[1] = '{18'd512, 18'd512, 18'd0, 1'b1};
    v[2] = '{18'd262143, 18'd1, 18'd262143, 1'b0};
    v[3] = '{18'd0, 18'd262143, 18'd0, 1'b0};
    v[4] = '{18'd1000, 18'd1000, 18'd213568, 1'b1};
    v[5] = '{18'd65535, 18'd4, 18'd262140, 1'b0};
    v[6] = '{18'd262143, 18'd262143, 18'd1, 1'b1};
    v[7] = '{18'd3, 18'd5, 18'd15, 1'b0};
    rst_n = 0; start_valid = 0; flush = 0; res_ready = 1; op_a = 0; op_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src1", add_src1, 0);
    chk("rst_src2", add_src2, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      mul(v[i].a, v[i].b, lat);
      chk($sformatf("latency[%0d]", i), lat, 18);
      chk($sformatf("result[%0d]", i), result, v[i].r);
      chk($sformatf("ovf[%0d]", i), ovf, v[i].o);
      chk($sformatf("busy_done[%0d]", i), busy, 1);
      if (v[i].a == 0) begin
        chk("zero_src2_nonzero", src2_nz, 0);
        chk("zero_run_cycles", run_obs, 18);
      end
      @(negedge clk);
      chk($sformatf("release[%0d]", i), start_ready, 1);
    end
    res_ready = 0;
    mul(18'd1000, 18'd1000, lat);
    chk("hold_latency", lat, 18);
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_result", result, 213568);
      chk("hold_ovf", ovf, 1);
      chk("hold_start_ready", start_ready, 0);
    end
    res_ready = 1;
    @(negedge clk);
    chk("hold_release_ready", start_ready, 1);
    chk("hold_release_busy", busy, 0);
    mul(18'd3, 18'd5, lat);
    chk("b2b_latency", lat, 18);
    chk("b2b_result", result, 15);
    chk("b2b_ovf", ovf, 0);
    mul(18'd512, 18'd512, lat);
    chk("pre_rst_ovf", ovf, 1);
    @(negedge clk);
    start_valid = 1; op_a = 100; op_b = 100;
    @(negedge clk);
    start_valid = 0;
    repeat (6) @(negedge clk);
    chk("mid_run_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("arst_start_ready", start_ready, 1);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_busy", busy, 0);
    chk("arst_src1", add_src1, 0);
    chk("arst_src2", add_src2, 0);
    @(negedge clk);
    rst_n = 1;
    mul(18'd7, 18'd9, lat);
    chk("post_rst_latency", lat, 18);
    chk("post_rst_result", result, 63);
    chk("post_rst_ovf", ovf, 0);
    @(negedge clk);
    start_valid = 1; op_a = 200; op_b = 300;
    @(negedge clk);
    start_valid = 0;
    repeat (3) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", busy, 0);
    chk("flush_start_ready", start_ready, 1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    chk("flush_no_result", seen, 0);
    start_valid = 1; flush = 1; op_a = 4; op_b = 4;
    @(negedge clk);
    start_valid = 0; flush = 0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_ready", start_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iter_mul18_ctrl.md
Name: iter_mul18_ctrl

Overview:
- Iterative 18-bit unsigned shift-add multiplier controller.
- Sits directly upstream of the existing 18-bit adder: drives its SRC1/SRC2 each cycle and consumes its Output to build the product.
- Used by the execute stage for multiply instructions.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 18, operand/result/adder width; the adder is instantiated at 18, and other values are untested.
- STEPS, 18, RUN cycles per multiply; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands present
- start_ready  output  1  controller can accept operands
- op_a  input  18  multiplicand (unsigned)
- op_b  input  18  multiplier (unsigned)
- flush  input  1  synchronous abort, returns to IDLE
- add_src1  output  18  to adder SRC1
- add_src2  output  18  to adder SRC2
- add_sum  input  18  from adder Output (SRC1+SRC2 mod 2^18, combinational)
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- result  output  18  low 18 bits of op_a*op_b
- ovf  output  1  1 iff true 36-bit product > 2^18-1
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; internal acc, mcand, mplier, count cleared.
  - Outputs: start_ready=1, res_valid=0, result=0, ovf=0, busy=0, add_src1=0, add_src2=0.
  - Reset asserted mid-RUN or mid-DONE discards the operation; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1; add_src1=add_src2=0.
  - On an edge with start_valid=1: load mcand=op_a, mplier=op_b, acc=0, count=0, ovf_int=0; go to RUN.
- RUN:
  - start_ready=0; add_src1=acc; add_src2 = mplier[0] ? mcand : 0.
  - Each edge:
    - acc <= add_sum
    - ovf_int set if add_sum < add_src1 (adder wrap)
    - ovf_int set if mplier[WIDTH-1:1]!=0 and mcand[WIDTH-1]=1 (a significant bit is shifted out)
    - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1
  - When count reaches STEPS-1, that edge also moves to DONE, registers result=add_sum and ovf = ovf_int OR the conditions of that final cycle.
  - No early termination: latency is fixed.
- Latency: res_valid rises exactly STEPS (18) clock edges after the accepting edge.
- DONE:
  - res_valid=1; result and ovf held stable until an edge with res_ready=1, which moves to IDLE.
  - start_ready stays 0 throughout DONE, so a new accept is possible at the earliest one cycle after the result is taken.
- result and ovf keep their last values in IDLE; they are valid only while res_valid=1.
- flush=1 at an edge in any state: go to IDLE, res_valid=0, drop the operation. flush has priority over start_valid and res_ready.
- Simultaneous start_valid and flush in IDLE: flush wins, nothing is accepted.
- busy=1 in RUN and DONE.
- Adder contract: add_sum must settle within one cycle; the block contains no arithmetic other than shifts, compares and the count increment.

Test Plan:
- op_a=123, op_b=456, res_ready=1 -> res_valid rises 18 edges after accept; result=56088 (18'b001101101100011000), ovf=0.
- op_a=512, op_b=512 -> result=0, ovf=1. Then op_a=262143, op_b=1 -> result=262143, ovf=0.
- op_a=0, op_b=262143 -> result=0, ovf=0; add_src2 observed 0 on all 18 RUN cycles.
- res_ready=0 for 10 cycles after res_valid -> result/ovf/res_valid held, start_ready=0. Raise res_ready -> IDLE next edge, start_ready=1; back-to-back 3*5=15 accepted.
- rst_n pulsed low at RUN cycle 7 -> all outputs immediately at reset values; the next multiply 7*9 yields 63 normally.
- flush at RUN cycle 4 -> IDLE next edge, no res_valid pulse. Also flush with start_valid in IDLE -> no accept.
